// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its IF/ID pipeline register.
`ifndef FETCH_STAGE_PKG_SV
`define FETCH_STAGE_PKG_SV
package fetch_stage_pkg;

  // All-zero word decodes as sll $0,$0,0, i.e. a NOP.
  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int WORD_BYTES = 4;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Value a flushed IF/ID register holds: a NOP marked as not valid.
  localparam if_id_t IF_ID_BUBBLE = '{instruction: NOP, pc_plus4: 32'h0, valid: 1'b0};

endpackage
`endif

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: captures an instruction and its PC+4 when loaded,
// drops to a bubble on flush. Flush beats load; reset behaves as a flush.
module if_id_register
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instruction_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  if_id_t data_q;
  if_id_t data_d;

  // Next value: bubble on flush, new capture on load, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (flush) begin
      data_d = IF_ID_BUBBLE;
    end else if (load) begin
      data_d = '{instruction: instruction_i, pc_plus4: pc_plus4_i, valid: 1'b1};
    end
  end

  // Register update with synchronous reset to the bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= IF_ID_BUBBLE;
    end else begin
      data_q <= data_d;
    end
  end

  assign instruction_o = data_q.instruction;
  assign pc_plus4_o    = data_q.pc_plus4;
  assign valid_o       = data_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, selects the next PC, tracks the
// sticky fetch fault and counts instructions delivered to IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_SIZE  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_address,
  input  logic [31:0] im_instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        fault
);

  localparam logic [29:0] IM_WORDS = 30'(IM_SIZE);

  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        fault_q, fault_d;
  logic        load, flush;
  logic [31:0] pc_plus4;
  logic        out_of_range;

  assign pc_plus4     = pc_q + 32'(WORD_BYTES);
  assign out_of_range = (pc_q[31:2] >= IM_WORDS);

  // Next-state selection, priority fault > redirect > stall > range check > fetch.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    fault_d = fault_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (fault_q) begin
      // Frozen: keep draining bubbles until reset.
      flush = 1'b1;
    end else if (redirect) begin
      pc_d  = {redirect_pc[31:2], 2'b00};
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
    end else if (stall) begin
      // Hold everything.
    end else if (out_of_range) begin
      fault_d = 1'b1;
      flush   = 1'b1;
    end else begin
      pc_d = pc_plus4;
      load = 1'b1;
      if (count_q != 32'hFFFF_FFFF) begin
        count_d = count_q + 32'd1;
      end
    end
  end

  // PC, counter and sticky fault registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      count_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  if_id_register u_if_id (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .flush         (flush),
    .instruction_i (im_instruction),
    .pc_plus4_i    (pc_plus4),
    .instruction_o (if_id_instruction),
    .pc_plus4_o    (if_id_pc_plus4),
    .valid_o       (if_id_valid)
  );

  assign pc          = pc_q;
  assign im_address  = pc_q;
  assign fetch_count = count_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a small-memory
// fault sequence and randomized traffic against a behavioural model.
module tb_fetch_stage;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  // DUT 1: full 64-word memory
  logic        d1_reset, d1_stall, d1_redirect;
  logic [31:0] d1_rpc, d1_im_addr, d1_im_instr, d1_pc, d1_instr, d1_pp4, d1_count;
  logic        d1_valid, d1_fault;

  // DUT 2: 4-word memory for the range fault
  logic        d2_reset, d2_stall, d2_redirect;
  logic [31:0] d2_rpc, d2_im_addr, d2_im_instr, d2_pc, d2_instr, d2_pp4, d2_count;
  logic        d2_valid, d2_fault;

  assign d1_im_instr = (d1_im_addr[31:2] < 30'd64) ? mem[d1_im_addr[7:2]] : 32'hDEAD_BEEF;
  assign d2_im_instr = (d2_im_addr[31:2] < 30'd64) ? mem[d2_im_addr[7:2]] : 32'hDEAD_BEEF;

  fetch_stage #(.RESET_PC(32'h0), .IM_SIZE(64)) dut1 (
    .clock(clock), .reset(d1_reset), .stall(d1_stall), .redirect(d1_redirect),
    .redirect_pc(d1_rpc), .im_address(d1_im_addr), .im_instruction(d1_im_instr),
    .pc(d1_pc), .if_id_instruction(d1_instr), .if_id_pc_plus4(d1_pp4),
    .if_id_valid(d1_valid), .fetch_count(d1_count), .fault(d1_fault)
  );

  fetch_stage #(.RESET_PC(32'h0), .IM_SIZE(4)) dut2 (
    .clock(clock), .reset(d2_reset), .stall(d2_stall), .redirect(d2_redirect),
    .redirect_pc(d2_rpc), .im_address(d2_im_addr), .im_instruction(d2_im_instr),
    .pc(d2_pc), .if_id_instruction(d2_instr), .if_id_pc_plus4(d2_pp4),
    .if_id_valid(d2_valid), .fetch_count(d2_count), .fault(d2_fault)
  );

  typedef struct {
    logic        rst, stl, rdr;
    logic [31:0] rpc;
    logic [31:0] pc, instr, pp4;
    logic        valid;
    logic [31:0] cnt;
    logic        flt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_d1(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pp4, input logic valid, input logic [31:0] cnt,
                        input logic flt);
    chk({tag, " pc"}, d1_pc, pc);
    chk({tag, " im_address"}, d1_im_addr, pc);
    chk({tag, " instr"}, d1_instr, instr);
    chk({tag, " pc_plus4"}, d1_pp4, pp4);
    chk({tag, " valid"}, 32'(d1_valid), 32'(valid));
    chk({tag, " count"}, d1_count, cnt);
    chk({tag, " fault"}, 32'(d1_fault), 32'(flt));
  endtask

  task automatic chk_d2(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pp4, input logic valid, input logic [31:0] cnt,
                        input logic flt);
    chk({tag, " pc"}, d2_pc, pc);
    chk({tag, " instr"}, d2_instr, instr);
    chk({tag, " pc_plus4"}, d2_pp4, pp4);
    chk({tag, " valid"}, 32'(d2_valid), 32'(valid));
    chk({tag, " count"}, d2_count, cnt);
    chk({tag, " fault"}, 32'(d2_fault), 32'(flt));
  endtask

  task automatic d2_cycle(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
    d2_reset = rst; d2_stall = stl; d2_redirect = rdr; d2_rpc = rpc;
    @(posedge clock);
    #1;
  endtask

  // Behavioural model of DUT 1 (specification rules, plain arithmetic)
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid, m_fault;

  task automatic model_step(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
    if (rst) begin
      m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_cnt = 0; m_fault = 0;
    end else if (m_fault) begin
      m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else if (rdr) begin
      m_pc = (rpc / 4) * 4;
      m_instr = 0; m_pp4 = 0; m_valid = 0;
      if (rpc % 4 != 0) m_fault = 1;
    end else if (stl) begin
      // hold
    end else if (m_pc / 4 >= 64) begin
      m_fault = 1; m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else begin
      m_instr = mem[m_pc / 4];
      m_pp4   = m_pc + 4;
      m_valid = 1;
      m_pc    = m_pc + 4;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h2009_0003;
  localparam logic [31:0] W2 = 32'h0109_5020;
  localparam logic [31:0] W3 = 32'h0000_0000;
  localparam logic [31:0] W8 = 32'h1000_0008;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3;

    d1_reset = 1; d1_stall = 0; d1_redirect = 0; d1_rpc = 0;
    d2_reset = 1; d2_stall = 0; d2_redirect = 0; d2_rpc = 0;

    // rst stl rdr rpc | pc instr pp4 valid cnt fault
    vq.push_back('{1, 0, 0, 32'h0,  32'h0,  32'h0, 32'h0,  0, 0, 0});
    vq.push_back('{0, 0, 0, 32'h0,  32'h4,  W0,    32'h4,  1, 1, 0});
    vq.push_back('{0, 0, 0, 32'h0,  32'h8,  W1,    32'h8,  1, 2, 0});
    vq.push_back('{0, 0, 0, 32'h0,  32'hC,  W2,    32'hC,  1, 3, 0});
    vq.push_back('{0, 0, 0, 32'h0,  32'h10, W3,    32'h10, 1, 4, 0});
    vq.push_back('{0, 0, 1, 32'h4,  32'h4,  32'h0, 32'h0,  0, 4, 0});
    vq.push_back('{0, 0, 0, 32'h0,  32'h8,  W1,    32'h8,  1, 5, 0});
    vq.push_back('{0, 1, 0, 32'h0,  32'h8,  W1,    32'h8,  1, 5, 0});
    vq.push_back('{0, 1, 0, 32'h0,  32'h8,  W1,    32'h8,  1, 5, 0});
    vq.push_back('{0, 0, 0, 32'h0,  32'hC,  W2,    32'hC,  1, 6, 0});
    vq.push_back('{0, 1, 1, 32'h20, 32'h20, 32'h0, 32'h0,  0, 6, 0});
    vq.push_back('{0, 0, 0, 32'h0,  32'h24, W8,    32'h24, 1, 7, 0});
    vq.push_back('{0, 0, 1, 32'h22, 32'h20, 32'h0, 32'h0,  0, 7, 1});
    vq.push_back('{0, 1, 0, 32'h0,  32'h20, 32'h0, 32'h0,  0, 7, 1});
    vq.push_back('{0, 0, 1, 32'h40, 32'h20, 32'h0, 32'h0,  0, 7, 1});
    vq.push_back('{0, 1, 1, 32'h44, 32'h20, 32'h0, 32'h0,  0, 7, 1});
    vq.push_back('{0, 0, 0, 32'h0,  32'h20, 32'h0, 32'h0,  0, 7, 1});
    vq.push_back('{0, 0, 1, 32'h8,  32'h20, 32'h0, 32'h0,  0, 7, 1});
    vq.push_back('{1, 1, 0, 32'h0,  32'h0,  32'h0, 32'h0,  0, 0, 0});
    vq.push_back('{0, 0, 0, 32'h0,  32'h4,  W0,    32'h4,  1, 1, 0});

    // Directed table on DUT 1
    for (int i = 0; i < vq.size(); i++) begin
      d1_reset = vq[i].rst; d1_stall = vq[i].stl; d1_redirect = vq[i].rdr; d1_rpc = vq[i].rpc;
      @(posedge clock);
      #1;
      chk_d1($sformatf("vec%0d", i), vq[i].pc, vq[i].instr, vq[i].pp4, vq[i].valid, vq[i].cnt, vq[i].flt);
      $display("vec %0d: rst=%0b stall=%0b redir=%0b rpc=%h -> pc=%h instr=%h valid=%0b cnt=%0d fault=%0b",
               i, vq[i].rst, vq[i].stl, vq[i].rdr, vq[i].rpc, d1_pc, d1_instr, d1_valid, d1_count, d1_fault);
    end

    // Range fault on the 4-word DUT
    d2_cycle(1, 0, 0, 0);
    chk_d2("d2 reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    d2_cycle(0, 0, 0, 0);
    d2_cycle(0, 0, 0, 0);
    d2_cycle(0, 0, 0, 0);
    d2_cycle(0, 0, 0, 0);
    chk_d2("d2 word3", 32'h10, W3, 32'h10, 1, 4, 0);
    $display("d2 after 4 fetches: pc=%h cnt=%0d fault=%0b", d2_pc, d2_count, d2_fault);
    d2_cycle(0, 0, 0, 0);
    chk_d2("d2 range fault", 32'h10, 32'h0, 32'h0, 0, 4, 1);
    $display("d2 range edge: pc=%h cnt=%0d fault=%0b", d2_pc, d2_count, d2_fault);
    d2_cycle(0, 1, 1, 32'h0);
    chk_d2("d2 frozen", 32'h10, 32'h0, 32'h0, 0, 4, 1);
    d2_cycle(1, 1, 0, 0);
    chk_d2("d2 reset in fault", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    d2_cycle(0, 0, 0, 0);
    chk_d2("d2 resume", 32'h4, W0, 32'h4, 1, 1, 0);
    $display("d2 after reset: pc=%h instr=%h cnt=%0d fault=%0b", d2_pc, d2_instr, d2_count, d2_fault);

    // Randomized traffic on DUT 1 against the model
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    model_step(1, 0, 0, 0);
    d1_reset = 1; d1_stall = 0; d1_redirect = 0; d1_rpc = 0;
    @(posedge clock);
    #1;
    chk_d1("rand reset", m_pc, m_instr, m_pp4, m_valid, m_cnt, m_fault);
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_stl, r_rdr;
      logic [31:0] r_rpc;
      r_rst = ($urandom_range(0, 24) == 0);
      r_stl = ($urandom_range(0, 3) == 0);
      r_rdr = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) r_rpc = 32'($urandom_range(0, 32'h1FF));
      else r_rpc = 32'($urandom_range(0, 71)) * 4;
      model_step(r_rst, r_stl, r_rdr, r_rpc);
      d1_reset = r_rst; d1_stall = r_stl; d1_redirect = r_rdr; d1_rpc = r_rpc;
      @(posedge clock);
      #1;
      chk_d1($sformatf("rand%0d", i), m_pc, m_instr, m_pp4, m_valid, m_cnt, m_fault);
      $display("rand %0d: rst=%0b stall=%0b redir=%0b rpc=%h -> pc=%h valid=%0b cnt=%0d fault=%0b",
               i, r_rst, r_stl, r_rdr, r_rpc, d1_pc, d1_valid, d1_count, d1_fault);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
